// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider. It produces one quotient bit per clock
// and uses a start/done handshake.

module rippleadder #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[W];
endmodule

module seq_divider #(
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] dividend,
    input  logic [K-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] quotient,
    output logic [K-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [K-1:0]  q_sr;
    logic [K-1:0]  d_reg;
    logic [K-1:0]  r_reg;
    logic [CW-1:0] cnt;

    logic [K:0]    r_sh;
    logic [K:0]    trial;
    logic          carry;
    logic [K-1:0]  r_new;
    logic [K-1:0]  q_new;
    logic          accept;
    logic          last;
    logic          unused_trial_msb;

    // R is kept at K bits: after restoration it never needs more, and the
    // extra bit only appears transiently in the shifted trial operand.
    assign r_sh = {r_reg, q_sr[K-1]};

    rippleadder #(.W(K + 1)) u_sub (
        .a    (r_sh),
        .b    (~{1'b0, d_reg}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (carry)
    );

    assign unused_trial_msb = trial[K];
    assign r_new  = carry ? trial[K-1:0] : r_sh[K-1:0];
    assign q_new  = {q_sr[K-2:0], carry};
    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CW'(1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sr        <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_sr        <= dividend;
            d_reg       <= divisor;
            r_reg       <= '0;
            cnt         <= CW'(K);
            div_by_zero <= (divisor == '0);
            // A zero divisor skips the iterations, so its results are published here.
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            q_sr  <= q_new;
            r_reg <= r_new;
            cnt   <= cnt - CW'(1);
            if (last) begin
                quotient  <= q_new;
                remainder <= r_new;
            end
        end
    end
endmodule
